// File: rtl/step_ctrl_pkg.sv
// Shared types and reset values for the step controller.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } deb_state_t;

  // Power-up direction is counting up, and stepping starts enabled.
  localparam logic UP_DOWN_RST = 1'b1;
  localparam logic RUNNING_RST = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debounce FSM that
// emits one single-cycle press pulse per accepted press.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_p0;
  logic          sync_p1;
  deb_state_t    state;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
    end
  end

  // --- synchronized level (sync_p1) feeds the debounce FSM ---

  // Debounce FSM: counter clears on every state entry, press pulse is registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!sync_p1) state <= ARM_PRESS;
        end
        ARM_PRESS: begin
          if (sync_p1) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (sync_p1) state <= ARM_RELEASE;
        end
        ARM_RELEASE: begin
          if (!sync_p1) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// Step controller: two debounced buttons toggle count direction and
// run/pause; while running a prescaler emits one step pulse per TICK_CYC.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int TICK_CYC     = 6000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_dir_n,
  input  logic btn_run_n,
  output logic up_down,
  output logic step,
  output logic running
);

  localparam int PW = $clog2(TICK_CYC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);

  logic          dir_press;
  logic          run_press;
  logic [PW-1:0] presc;
  logic          presc_last;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_dir (
    .clk   (clk),
    .rstn  (rstn),
    .btn_n (btn_dir_n),
    .press (dir_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_run (
    .clk   (clk),
    .rstn  (rstn),
    .btn_n (btn_run_n),
    .press (run_press)
  );

  // --- press pulses feed the control registers ---

  assign presc_last = (presc == PRESC_LAST);

  // Direction/run toggles and prescaler; a pause request suppresses a coincident step.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      up_down <= UP_DOWN_RST;
      running <= RUNNING_RST;
      step    <= 1'b0;
      presc   <= '0;
    end else begin
      up_down <= up_down ^ dir_press;
      running <= running ^ run_press;
      step    <= running & ~run_press & presc_last;
      if (!running) begin
        presc <= '0;
      end else if (presc_last) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DEBOUNCE_CYC=4, TICK_CYC=5.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int TICK = 5;

  logic clk = 1'b0;
  logic rstn;
  logic btn_dir_n;
  logic btn_run_n;
  logic up_down;
  logic step;
  logic running;

  int n_chk  = 0;
  int n_fail = 0;

  step_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .TICK_CYC     (TICK)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_dir_n (btn_dir_n),
    .btn_run_n (btn_run_n),
    .up_down   (up_down),
    .step      (step),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until step is seen (bounded); returns right after the step edge.
  task automatic wait_step();
    int found;
    found = 0;
    for (int i = 0; i < 2 * TICK + 2; i++) begin
      tick();
      if (step) begin
        found = 1;
        break;
      end
    end
    check("wait_step", found, 1);
  endtask

  initial begin
    int nsteps;
    rstn      = 1'b0;
    btn_dir_n = 1'b1;
    btn_run_n = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_running", running, 1);
    check("rst_up_down", up_down, 1);
    check("rst_step",    step,    0);

    // Free-running steps after release: edges 5 and 10
    rstn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("boot_step_%0d", i), step, (i % 5 == 0) ? 1 : 0);
    end
    check("boot_up_down", up_down, 1);

    // 3-cycle glitch on dir: rejected
    btn_dir_n = 1'b0;
    repeat (3) tick();
    btn_dir_n = 1'b1;
    repeat (15) tick();
    check("glitch_up_down", up_down, 1);

    // Dir press timed so its toggle lands on a prescaler wrap
    wait_step();
    tick();
    tick();
    btn_dir_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        check("align_pre_step",    step,    0);
        check("align_pre_up_down", up_down, 1);
      end
      if (i == 8) begin
        check("align_step",    step,    1);
        check("align_up_down", up_down, 0);
      end
    end
    // Keep holding: still exactly one toggle
    repeat (12) tick();
    check("hold_up_down", up_down, 0);

    // Release with 2-cycle bounces
    btn_dir_n = 1'b1; repeat (2) tick();
    btn_dir_n = 1'b0; repeat (2) tick();
    btn_dir_n = 1'b1; repeat (2) tick();
    btn_dir_n = 1'b0; repeat (2) tick();
    check("bounce_up_down", up_down, 0);
    btn_dir_n = 1'b1;
    repeat (6) tick();
    check("bounce_arm_release", 32'(dut.u_dir.state), 32'(ARM_RELEASE));
    tick();
    check("bounce_idle", 32'(dut.u_dir.state), 32'(IDLE));
    repeat (10) tick();
    check("bounce_final_up_down", up_down, 0);

    // Run press: pause
    btn_run_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("pause_pre_running", running, 1);
    end
    check("pause_running", running, 0);
    repeat (4) tick();
    btn_run_n = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step) nsteps++;
    end
    check("pause_no_steps",    nsteps,  0);
    check("pause_running_held", running, 0);

    // Second press: resume, first step 5 cycles after running rises
    btn_run_n = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 8) check("resume_running", running, 1);
      if (i >= 9 && i <= 12) check($sformatf("resume_quiet_%0d", i), step, 0);
      if (i == 13) check("resume_step", step, 1);
    end
    repeat (4) tick();
    btn_run_n = 1'b1;
    repeat (10) tick();

    // Pause request coinciding with a wrap: pause wins
    wait_step();
    tick();
    tick();
    btn_run_n = 1'b0;
    repeat (8) tick();
    check("pausewrap_step",    step,    0);
    check("pausewrap_running", running, 0);
    repeat (4) tick();
    btn_run_n = 1'b1;
    repeat (10) tick();
    check("pre_rst_running", running, 0);
    check("pre_rst_up_down", up_down, 0);

    // Reset mid-debounce with running=0, up_down=0
    btn_dir_n = 1'b0;
    repeat (5) tick();
    rstn      = 1'b0;
    btn_dir_n = 1'b1;
    tick();
    check("rst2_running", running, 1);
    check("rst2_up_down", up_down, 1);
    check("rst2_step",    step,    0);
    rstn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("rst2_step_%0d", i), step, (i % 5 == 0) ? 1 : 0);
    end
    check("rst2_no_late_press", up_down, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
